// File: rtl/audio_pkg.sv
// Shared types and defaults for the audio-in capture path.
package audio_pkg;

  typedef enum logic [1:0] {IDLE, SKIP, SHIFT, WAIT_LRCK} state_t;
  typedef enum logic {LEFT, RIGHT} chan_t;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int I2S_BCLK_SKIP      = 1;

endpackage

// File: rtl/audio_word_shifter.sv
// MSB-first serial-to-parallel word shifter with a terminal-count bit counter.
// done and word_next are combinational so the caller can act on the final bit in the same cycle.
module audio_word_shifter
  import audio_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  shift,
  input  logic                  bit_in,
  output logic [DATA_WIDTH-1:0] word_next,
  output logic                  done
);

  localparam int CW = $clog2(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  always_comb begin
    word_next = {word_q[DATA_WIDTH-2:0], bit_in};
    done      = shift && (cnt_q == '0);
    word_d    = word_q;
    cnt_d     = cnt_q;
    if (clear) begin
      word_d = '0;
      cnt_d  = CW'(DATA_WIDTH - 1);
    end else if (shift) begin
      word_d = word_next;
      cnt_d  = done ? CW'(DATA_WIDTH - 1) : cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/audio_in_deserializer.sv
// I2S capture: turns BCLK/LRCK edge pulses plus ADCDAT into left/right pairs on a valid/ready port.
//
//   state     | meaning
//   IDLE      | waiting for an LRCK falling edge to start a left word
//   SKIP      | ignoring the BCLK_SKIP edges before the MSB
//   SHIFT     | shifting DATA_WIDTH bits in, MSB first
//   WAIT_LRCK | word captured; padding bits ignored until the next LRCK edge
module audio_in_deserializer
  import audio_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int BCLK_SKIP  = I2S_BCLK_SKIP
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  bclk_rising,
  input  logic                  lrck_rising,
  input  logic                  lrck_falling,
  input  logic                  serial_data,
  output logic [DATA_WIDTH-1:0] left_data,
  output logic [DATA_WIDTH-1:0] right_data,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  overflow,
  output logic                  framing_error,
  input  logic                  clear_errors
);

  localparam int SKW = (BCLK_SKIP < 2) ? 1 : $clog2(BCLK_SKIP + 1);

  state_t                state_q, state_d;
  chan_t                 chan_q, chan_d;
  logic [SKW-1:0]        skip_q, skip_d;
  logic [DATA_WIDTH-1:0] left_hold_q, left_hold_d;
  logic [DATA_WIDTH-1:0] left_q, left_d, right_q, right_d;
  logic                  valid_q, valid_d;
  logic                  overflow_q, overflow_d;
  logic                  ferr_q, ferr_d;

  logic                  sh_clear, sh_shift, sh_done;
  logic [DATA_WIDTH-1:0] sh_word;
  logic                  start;
  chan_t                 start_chan;
  logic                  pair_done;

  audio_word_shifter #(.DATA_WIDTH(DATA_WIDTH)) u_shifter (
    .clk       (clk),
    .reset     (reset),
    .clear     (sh_clear),
    .shift     (sh_shift),
    .bit_in    (serial_data),
    .word_next (sh_word),
    .done      (sh_done)
  );

  always_comb begin
    state_d     = state_q;
    chan_d      = chan_q;
    skip_d      = skip_q;
    left_hold_d = left_hold_q;
    left_d      = left_q;
    right_d     = right_q;
    valid_d     = valid_q;
    overflow_d  = overflow_q;
    ferr_d      = ferr_q;
    sh_clear    = 1'b0;
    sh_shift    = 1'b0;
    start       = 1'b0;
    start_chan  = LEFT;
    pair_done   = 1'b0;

    if (valid_q && data_ready) valid_d = 1'b0;
    // Errors are set after the clear below, so a coincident error keeps its flag.
    if (clear_errors) begin
      overflow_d = 1'b0;
      ferr_d     = 1'b0;
    end

    if (!enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (lrck_falling) start = 1'b1;
        end
        SKIP, SHIFT: begin
          if (lrck_falling) begin
            ferr_d = 1'b1;
            start  = 1'b1;
          end else if (lrck_rising) begin
            ferr_d  = 1'b1;
            state_d = IDLE;
          end else if (bclk_rising) begin
            if (state_q == SKIP) begin
              if (skip_q <= SKW'(1)) state_d = SHIFT;
              else                   skip_d  = skip_q - SKW'(1);
            end else begin
              sh_shift = 1'b1;
              if (sh_done) begin
                state_d = WAIT_LRCK;
                if (chan_q == LEFT) left_hold_d = sh_word;
                else                pair_done   = 1'b1;
              end
            end
          end
        end
        WAIT_LRCK: begin
          if (lrck_rising) begin
            start = 1'b1;
            if (chan_q == LEFT) start_chan = RIGHT;
            else                ferr_d     = 1'b1;
          end else if (lrck_falling) begin
            start = 1'b1;
            if (chan_q == LEFT) ferr_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (start) begin
      chan_d   = start_chan;
      sh_clear = 1'b1;
      skip_d   = SKW'(BCLK_SKIP);
      state_d  = (BCLK_SKIP == 0) ? SHIFT : SKIP;
    end

    if (pair_done) begin
      if (valid_q && !data_ready) begin
        overflow_d = 1'b1;
      end else begin
        left_d  = left_hold_q;
        right_d = sh_word;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      chan_q      <= LEFT;
      skip_q      <= '0;
      left_hold_q <= '0;
      left_q      <= '0;
      right_q     <= '0;
      valid_q     <= 1'b0;
      overflow_q  <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      chan_q      <= chan_d;
      skip_q      <= skip_d;
      left_hold_q <= left_hold_d;
      left_q      <= left_d;
      right_q     <= right_d;
      valid_q     <= valid_d;
      overflow_q  <= overflow_d;
      ferr_q      <= ferr_d;
    end
  end

  assign left_data     = left_q;
  assign right_data    = right_q;
  assign data_valid    = valid_q;
  assign overflow      = overflow_q;
  assign framing_error = ferr_q;

endmodule

// File: tb/tb_audio_in_deserializer.sv
// Scoreboard bench: stimulus pushes expected {left,right} pairs, a negedge monitor pops on each accept.
module tb_audio_in_deserializer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        bclk_rising = 1'b0;
  logic        lrck_rising = 1'b0;
  logic        lrck_falling = 1'b0;
  logic        serial_data = 1'b0;
  logic [15:0] left_data, right_data;
  logic        data_valid;
  logic        data_ready = 1'b1;
  logic        overflow, framing_error;
  logic        clear_errors = 1'b0;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  audio_in_deserializer #(.DATA_WIDTH(16), .BCLK_SKIP(1)) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .bclk_rising   (bclk_rising),
    .lrck_rising   (lrck_rising),
    .lrck_falling  (lrck_falling),
    .serial_data   (serial_data),
    .left_data     (left_data),
    .right_data    (right_data),
    .data_valid    (data_valid),
    .data_ready    (data_ready),
    .overflow      (overflow),
    .framing_error (framing_error),
    .clear_errors  (clear_errors)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted pair must match the oldest expected pair.
  always @(negedge clk) begin
    if (!reset && data_valid && data_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pair: got %h%h expected none at %0t", left_data, right_data, $time);
      end else begin
        chk("pair", {left_data, right_data}, exp_q.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bclk(input bit d);
    serial_data = d;
    bclk_rising = 1'b1;
    tick(1);
    bclk_rising = 1'b0;
    tick(2);
  endtask

  task automatic lrck(input bit r);
    if (r) lrck_rising = 1'b1;
    else   lrck_falling = 1'b1;
    tick(1);
    lrck_rising  = 1'b0;
    lrck_falling = 1'b0;
    tick(2);
  endtask

  // One channel slot: LRCK edge, one skip edge, nbits data bits MSB first, random padding up to nb edges.
  task automatic channel(input bit r, input logic [15:0] w, input int nb, input int nbits);
    lrck(r);
    bclk(1'($urandom));
    for (int i = 0; i < nbits; i++) bclk(w[15-i]);
    for (int i = nbits + 1; i < nb; i++) bclk(1'($urandom));
  endtask

  task automatic frame(input logic [15:0] l, input logic [15:0] r, input int nb, input bit push);
    if (push) exp_q.push_back({l, r});
    channel(1'b0, l, nb, 16);
    channel(1'b1, r, nb, 16);
  endtask

  task automatic pulse_clear();
    clear_errors = 1'b1;
    tick(1);
    clear_errors = 1'b0;
  endtask

  initial begin
    logic [15:0] l, r;
    tick(3);
    chk("rst_valid", 32'(data_valid), 0);
    chk("rst_left", 32'(left_data), 0);
    chk("rst_right", 32'(right_data), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_ferr", 32'(framing_error), 0);
    reset  = 1'b0;
    enable = 1'b1;
    tick(2);

    // Basic frame with latency check on the final right bit.
    exp_q.push_back({16'hA5C3, 16'h0F1E});
    channel(1'b0, 16'hA5C3, 17, 16);
    l = 16'h0F1E;
    lrck(1'b1);
    bclk(1'b0);
    for (int i = 0; i < 15; i++) bclk(l[15-i]);
    serial_data = l[0];
    bclk_rising = 1'b1;
    tick(1);
    bclk_rising = 1'b0;
    chk("lat_valid_set", 32'(data_valid), 1);
    tick(1);
    chk("lat_valid_drop", 32'(data_valid), 0);
    tick(4);

    // Overflow: ready low, second pair dropped, clear restores flag only.
    data_ready = 1'b0;
    frame(16'h1111, 16'h2222, 17, 1'b1);
    frame(16'h3333, 16'h4444, 17, 1'b0);
    tick(2);
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_held", {left_data, right_data}, {16'h1111, 16'h2222});
    chk("ovf_valid", 32'(data_valid), 1);
    pulse_clear();
    tick(1);
    chk("ovf_clear", 32'(overflow), 0);
    chk("ovf_held2", {left_data, right_data}, {16'h1111, 16'h2222});
    data_ready = 1'b1;
    tick(3);
    chk("ovf_drained", 32'(data_valid), 0);

    // Truncated left word: rising LRCK after 10 bits.
    channel(1'b0, 16'hFFFF, 11, 10);
    lrck(1'b1);
    for (int i = 0; i < 17; i++) bclk(1'($urandom));
    chk("ferr_set", 32'(framing_error), 1);
    pulse_clear();
    tick(1);
    chk("ferr_clear", 32'(framing_error), 0);
    frame(16'h1234, 16'h5678, 17, 1'b1);
    tick(2);
    chk("ferr_after", 32'(framing_error), 0);

    // 32 BCLKs per channel, MSB-aligned capture.
    frame(16'h8001, 16'h7FFE, 32, 1'b1);
    tick(2);

    // Enable dropped mid right word.
    channel(1'b0, 16'hDEAD, 17, 16);
    lrck(1'b1);
    bclk(1'b0);
    for (int i = 0; i < 5; i++) bclk(1'($urandom));
    enable = 1'b0;
    tick(2);
    enable = 1'b1;
    for (int i = 0; i < 11; i++) bclk(1'($urandom));
    channel(1'b1, 16'hBEEF, 17, 16);
    chk("en_no_ferr", 32'(framing_error), 0);
    frame(16'hCAFE, 16'hF00D, 17, 1'b1);
    tick(2);

    // Async reset mid-SHIFT while a pair is held.
    data_ready = 1'b0;
    frame(16'h5A5A, 16'hA5A5, 17, 1'b0);
    tick(2);
    chk("pre_rst_valid", 32'(data_valid), 1);
    lrck(1'b0);
    bclk(1'b0);
    for (int i = 0; i < 5; i++) bclk(1'($urandom));
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", 32'(data_valid), 0);
    chk("arst_data", {left_data, right_data}, 0);
    tick(2);
    reset = 1'b0;
    data_ready = 1'b1;
    for (int i = 0; i < 10; i++) bclk(1'($urandom));
    frame(16'h0F0F, 16'hF0F0, 17, 1'b1);
    tick(2);

    // Randomized frames with random slot widths.
    for (int n = 0; n < 20; n++) begin
      l = 16'($urandom);
      r = 16'($urandom);
      frame(l, r, int'($urandom_range(17, 32)), 1'b1);
    end
    tick(20);
    chk("queue_empty", 32'(exp_q.size()), 0);
    chk("final_ovf", 32'(overflow), 0);
    chk("final_ferr", 32'(framing_error), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
